// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// datapath mux selects and the alu_control codes understood by the ALU.
package ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Per-state control word; pc_update and branch combine into pc_write.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU decoder: maps alu_op plus instruction function bits
// onto the 3-bit alu_control code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, whose imm[10] lands on funct7b5
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I-subset control unit (Moore FSM). Optional illegal-opcode
// trap state and illegal_op port enabled by MC_CONTROLLER_ILLEGAL_EN.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control
`ifdef MC_CONTROLLER_ILLEGAL_EN
    ,
    output logic       illegal_op
`endif
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_ITYPE:     state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
`ifdef MC_CONTROLLER_ILLEGAL_EN
                    default:      state_next = S_TRAP;
`else
                    default:      state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXECR:   state_next = S_ALUWB;
            S_EXECI:   state_next = S_ALUWB;
            S_JAL:     state_next = S_ALUWB;
`ifdef MC_CONTROLLER_ILLEGAL_EN
            S_TRAP:    state_next = S_TRAP;
`endif
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

    // Write enables are masked by reset so an abort never leaks a write.
    assign pc_write   = ~reset & (ctrl.pc_update | (ctrl.branch & zero));
    assign ir_write   = ~reset & ctrl.ir_write;
    assign mem_write  = ~reset & ctrl.mem_write;
    assign reg_write  = ~reset & ctrl.reg_write;
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign imm_src    = imm_src_of(op);

`ifdef MC_CONTROLLER_ILLEGAL_EN
    assign illegal_op = ~reset & (state == S_TRAP);
`endif

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed table, hand-written
// reset/illegal-op sequences, and random instructions against a reference model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
`ifdef MC_CONTROLLER_ILLEGAL_EN
    logic       illegal_op;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .reg_write   (reg_write),
        .alu_control (alu_control)
`ifdef MC_CONTROLLER_ILLEGAL_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    // Observable outputs of one cycle: pc_write, adr_src, mem_write, ir_write,
    // reg_write, result_src, alu_src_a, alu_src_b, alu_control.
    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       ir;
        logic       rw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
    } obs_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cycles;
        logic [2:0] alu3;
        logic       pcw3;
        logic [1:0] imm;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic obs_t sample();
        return obs_t'({pc_write, adr_src, mem_write, ir_write, reg_write,
                       result_src, alu_src_a, alu_src_b, alu_control});
    endfunction

    function automatic obs_t mk(logic pcw, logic adr, logic mw, logic ir, logic rw,
                                logic [1:0] res, logic [1:0] a, logic [1:0] b, logic [2:0] alu);
        return obs_t'({pcw, adr, mw, ir, rw, res, a, b, alu});
    endfunction

    // ALU operation an R/I instruction asks for, as its alu_control code.
    function automatic logic [2:0] arith_code(logic is_r, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_expect(logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Reference model: the list of per-cycle outputs one instruction produces.
    function automatic void build(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
        obs_t wb;
        wb = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000);
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000));
        case (o)
            7'b0000011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000));
                exp_q.push_back(mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
                exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000));
            end
            7'b0100011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000));
                exp_q.push_back(mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000));
            end
            7'b0110011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, arith_code(1'b1, f3, f7)));
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, arith_code(1'b0, f3, f7)));
                exp_q.push_back(wb);
            end
            7'b1100011: exp_q.push_back(mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001));
            7'b1101111: begin
                exp_q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000));
                exp_q.push_back(wb);
            end
            default: ;
        endcase
    endfunction

    // Called just after a posedge with the FSM in FETCH; returns in FETCH.
    task automatic run_model(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        build(o, f3, f7, z);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, i), 64'(sample()), 64'(exp_q[i]));
            if (i == 0) check($sformatf("%s_imm", tag), 64'(imm_src), 64'(imm_expect(o)));
            @(posedge clk); #1;
        end
        check($sformatf("%s_back_to_fetch", tag), 64'(ir_write), 64'(1));
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc;
        logic [2:0] alu3;
        logic       pcw3;
        logic [1:0] imm;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        cyc = 0; alu3 = 'x; pcw3 = 'x; imm = 'x;
        do begin
            @(negedge clk);
            if (cyc == 0) imm = imm_src;
            if (cyc == 2) begin
                alu3 = alu_control;
                pcw3 = pc_write;
            end
            cyc++;
            @(posedge clk); #1;
        end while (!ir_write && cyc < 12);
        check({v.name, "_cycles"}, 64'(cyc), 64'(v.cycles));
        check({v.name, "_alu3"}, 64'(alu3), 64'(v.alu3));
        check({v.name, "_pcw3"}, 64'(pcw3), 64'(v.pcw3));
        check({v.name, "_imm"}, 64'(imm), 64'(v.imm));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [7];
        int         n_ops;

        vecs.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0, 2'b00});
        vecs.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 1'b1, 4, 3'b000, 1'b0, 2'b01});
        vecs.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0, 2'b00});
        vecs.push_back('{"sub",   7'b0110011, 3'b000, 1'b1, 1'b1, 4, 3'b001, 1'b0, 2'b00});
        vecs.push_back('{"addi7", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0, 2'b00});
        vecs.push_back('{"slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0, 2'b00});
        vecs.push_back('{"ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0, 2'b00});
        vecs.push_back('{"andi",  7'b0010011, 3'b111, 1'b1, 1'b0, 4, 3'b010, 1'b0, 2'b00});
        vecs.push_back('{"sll",   7'b0110011, 3'b001, 1'b1, 1'b0, 4, 3'b000, 1'b0, 2'b00});
        vecs.push_back('{"beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1, 2'b10});
        vecs.push_back('{"beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 2'b10});
        vecs.push_back('{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1, 2'b11});

        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_enables", 64'({pc_write, ir_write, mem_write, reg_write}), 64'(0));
        check("reset_fetch_sel", 64'({adr_src, result_src, alu_src_a, alu_src_b, alu_control}),
              64'({1'b0, 2'b10, 2'b00, 2'b10, 3'b000}));
        @(posedge clk); #1;
        reset = 1'b0;

        run_model("lw_first", 7'b0000011, 3'b010, 1'b0, 1'b1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted asynchronously in the middle of MEMWRITE.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("memwrite_before_reset", 64'(mem_write), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("memwrite_dropped", 64'({pc_write, ir_write, mem_write, reg_write}), 64'(0));
        check("reset_to_fetch", 64'({adr_src, result_src, alu_src_b}), 64'({1'b0, 2'b10, 2'b10}));
        @(posedge clk); #1;
        check("held_reset_enables", 64'({pc_write, ir_write, mem_write, reg_write}), 64'(0));
        reset = 1'b0;
        #1;
        check("release_fetch", 64'({pc_write, ir_write}), 64'(2'b11));
        @(posedge clk); #1;
        check("release_decode", 64'({ir_write, alu_src_a, alu_src_b}), 64'({1'b0, 2'b01, 2'b01}));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("sw_resume_fetch", 64'(ir_write), 64'(1));

`ifdef MC_CONTROLLER_ILLEGAL_EN
        op = 7'b1111111;
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("trap_hold_%0d", k),
                  64'({illegal_op, pc_write, ir_write, mem_write, reg_write}), 64'(5'b10000));
        end
        reset = 1'b1;
        #1;
        check("trap_reset_clears", 64'(illegal_op), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("trap_reset_fetch", 64'({illegal_op, ir_write}), 64'(2'b01));
        n_ops = 6;
`else
        run_model("illegal", 7'b1111111, 3'b000, 1'b0, 1'b1);
        n_ops = 7;
`endif

        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b1111111;
        for (int n = 0; n < 150; n++) begin
            run_model($sformatf("rnd%0d", n), ops[$urandom_range(0, n_ops - 1)],
                      3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit; drives the datapath ALU and consumes its zero flag.
- Decodes the instruction register fields for the RV32I subset: lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq, jal.
- Sequences one instruction over 3-5 cycles with a Moore FSM.
- Produces mux selects, write enables and the 3-bit alu_control code consumed by the ALU.

Parameters:
- None; all encodings are fixed in ctrl_pkg.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; FSM to FETCH
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag, result==0
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address mux: 0=PC, 1=ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register enable
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

Behaviour:
- State register is updated on posedge clk; reset is asynchronous and active-high; reset state is FETCH.
- While reset=1: pc_write, ir_write, mem_write and reg_write are forced to 0; all other outputs take their FETCH values.
- All outputs are decoded combinationally from state, except:
  - pc_write = pc_update | (branch & zero), evaluated combinationally in BEQ.
  - imm_src is decoded from op only: lw/I-ALU -> 00, sw -> 01, beq -> 10, jal -> 11, else 00.
- Default output values are 0 and alu_op=00, unless listed below.
- States and outputs:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_update=1 -> DECODE.
  - DECODE: a=01, b=01, alu_op=00. Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - otherwise -> FETCH
  - MEMADR: a=10, b=01, alu_op=00 -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: result_src=00, adr_src=1 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1 -> FETCH.
  - EXECR: a=10, b=00, alu_op=10 -> ALUWB.
  - EXECI: a=10, b=01, alu_op=10 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- ALU decode:
  - alu_op=00 -> add.
  - alu_op=01 -> sub.
  - alu_op=10, by funct3:
    - 000 -> sub if op[5] & funct7b5, else add. addi with imm[10]=1 must stay add.
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add
- Cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Reset mid-instruction aborts immediately; no write enable is asserted in the cycle reset is seen.

Optional Feature:
- Macro: MC_CONTROLLER_ILLEGAL_EN.
- Defined:
  - Adds output port illegal_op (1 bit) and state TRAP.
  - Unknown op in DECODE goes to TRAP.
  - TRAP is sticky until reset: illegal_op=1, all write enables 0.
  - illegal_op=0 in every other state and during reset.
- Undefined: no port and no TRAP state; unknown op returns to FETCH without side effects.

Decomposition:
- ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode localparams
  - alu_control code localparams, shared with the ALU
  - alu_op, result_src, alu_src_a/b and imm_src encodings
- Natural sub-module: alu_decoder, combinational (alu_op, funct3, funct7b5, op5 -> alu_control), instantiated once.

Test Plan:
- Reset released with op=0000011 (lw): cycles show FETCH(ir_write=1, pc_write=1), DECODE, MEMADR(alu_control=000), MEMREAD(adr_src=1), MEMWB(result_src=01, reg_write=1), then FETCH; 5 cycles total.
- op=0110011, funct3=000, funct7b5=1 -> EXECR alu_control=001. Same with op=0010011 (addi) and funct7b5=1 -> alu_control=000.
- beq (op=1100011) with zero=1 in BEQ -> pc_write=1, alu_control=001. With zero=0 -> pc_write=0. Next state is FETCH in both cases.
- jal (op=1101111) -> JAL(pc_write=1, a=01, b=10), then ALUWB(reg_write=1), then FETCH; imm_src=11 throughout.
- reset asserted asynchronously mid-MEMWRITE -> mem_write drops to 0 the same delta, before any clk edge; state becomes FETCH; after release the next edge enters DECODE.
- op=1111111 -> without macro: DECODE then FETCH, no enables. With MC_CONTROLLER_ILLEGAL_EN: TRAP, illegal_op=1 held for 10+ cycles, cleared only by reset.
